stream_capture_reader: RTL and testbench

- Sink end of the processing-chain stream: consumes a 64-bit signed sample stream (data/data_valid, the output of the moving-average and IIR filters).
- Captures a programmed number of samples into on-chip RAM, then lets the host/NIOS side drain them through a simple read-request port.
- Replaces the ad-hoc "fifo_lleno" counting in the filters with one block that owns capture framing, fullness and readout.

---
 rtl/stream_capture_reader.sv | 183 ++++++++++++++++++
 tb/tb_stream_capture_reader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_capture_reader.sv
// Sink for the filtered 64-bit sample stream: frames a programmed number of samples into a
// buffer RAM, then drains them on rd_req. Define CAPTURE_SPLIT32_EN for 32-bit two-word readout.
module stream_capture_reader #(
   parameter int DATA_W       = 64,
   parameter int DEPTH        = 2048,
   parameter int ADDR_W       = 11,
   parameter int SKIP_SAMPLES = 0
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_enable,
   input  logic              i_data_valid,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_arm,
   input  logic [15:0]       i_capture_len,
   input  logic              i_rd_req,
`ifdef CAPTURE_SPLIT32_EN
   output logic [31:0]       o_rd_data,
`else
   output logic [DATA_W-1:0] o_rd_data,
`endif
   output logic              o_rd_valid,
   output logic              o_busy,
   output logic              o_fifo_lleno,
   output logic [15:0]       o_sample_count,
   output logic              o_rd_ignored
);

   // state     | meaning
   // S_IDLE    | waiting for arm; incoming samples dropped
   // S_SKIP    | discarding settling samples after arm
   // S_CAPTURE | writing samples into the buffer
   // S_FULL    | capture complete, host draining the buffer
   typedef enum logic [1:0] {S_IDLE, S_SKIP, S_CAPTURE, S_FULL} state_t;

   localparam logic [15:0] DEPTH_L = 16'(DEPTH);
   localparam logic [15:0] SKIP_L  = 16'(SKIP_SAMPLES);

   state_t            r_state;
   logic [15:0]       r_wr_ptr;
   logic [15:0]       r_rd_ptr;
   logic [15:0]       r_sample_count;
   logic [15:0]       r_skip_cnt;
   logic [15:0]       r_len_q;
   logic              r_rd_valid;
   logic              r_busy;
   logic              r_fifo_lleno;
   logic              r_rd_ignored;
`ifdef CAPTURE_SPLIT32_EN
   logic [31:0]       r_rd_data;
   logic              r_half;
`else
   logic [DATA_W-1:0] r_rd_data;
`endif
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_sample;
   logic              w_wr_en;
   logic              w_rd_accept;
   logic              w_rd_done;
   logic              w_last_rd;
   logic [15:0]       w_len_eff;
   logic [DATA_W-1:0] w_rd_word;

   assign w_sample    = i_enable && i_data_valid;
   assign w_wr_en     = (r_state == S_CAPTURE) && w_sample;
   assign w_rd_accept = i_rd_req && (r_state == S_FULL) && (r_rd_ptr < r_sample_count);
   assign w_last_rd   = (r_rd_ptr == r_sample_count - 16'd1);
   assign w_len_eff   = (i_capture_len == 16'd0 || i_capture_len > DEPTH_L) ? DEPTH_L
                                                                             : i_capture_len;
   assign w_rd_word   = r_mem[r_rd_ptr[ADDR_W-1:0]];
`ifdef CAPTURE_SPLIT32_EN
   assign w_rd_done   = w_rd_accept && r_half;
`else
   assign w_rd_done   = w_rd_accept;
`endif

   // Buffer RAM: contents survive reset; reads only happen in S_FULL so no overlap with writes.
   always_ff @(posedge i_clock) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_data;
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state        <= S_IDLE;
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_sample_count <= '0;
         r_skip_cnt     <= '0;
         r_len_q        <= '0;
         r_rd_valid     <= 1'b0;
         r_busy         <= 1'b0;
         r_fifo_lleno   <= 1'b0;
         r_rd_ignored   <= 1'b0;
         r_rd_data      <= '0;
`ifdef CAPTURE_SPLIT32_EN
         r_half         <= 1'b0;
`endif
      end else begin
         r_rd_valid <= 1'b0;
         if (i_rd_req && !w_rd_accept) begin
            r_rd_ignored <= 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (i_enable && i_arm) begin
                  r_len_q        <= w_len_eff;
                  r_wr_ptr       <= '0;
                  r_rd_ptr       <= '0;
                  r_sample_count <= '0;
                  r_skip_cnt     <= '0;
                  // a read request in the arm cycle is still reported after the clear
                  r_rd_ignored   <= i_rd_req;
                  r_busy         <= 1'b1;
`ifdef CAPTURE_SPLIT32_EN
                  r_half         <= 1'b0;
`endif
                  if (SKIP_SAMPLES > 0) begin
                     r_state <= S_SKIP;
                  end else begin
                     r_state <= S_CAPTURE;
                  end
               end
            end

            S_SKIP: begin
               if (w_sample) begin
                  r_skip_cnt <= r_skip_cnt + 16'd1;
                  if (r_skip_cnt + 16'd1 == SKIP_L) begin
                     r_state <= S_CAPTURE;
                  end
               end
            end

            S_CAPTURE: begin
               if (w_sample) begin
                  r_wr_ptr       <= r_wr_ptr + 16'd1;
                  r_sample_count <= r_sample_count + 16'd1;
                  if (r_sample_count + 16'd1 == r_len_q) begin
                     r_state      <= S_FULL;
                     r_busy       <= 1'b0;
                     r_fifo_lleno <= 1'b1;
                  end
               end
            end

            S_FULL: begin
               if (w_rd_accept) begin
                  r_rd_valid <= 1'b1;
`ifdef CAPTURE_SPLIT32_EN
                  r_rd_data  <= r_half ? w_rd_word[32 +: 32] : w_rd_word[31:0];
                  r_half     <= ~r_half;
`else
                  r_rd_data  <= w_rd_word;
`endif
                  if (w_rd_done) begin
                     r_rd_ptr <= r_rd_ptr + 16'd1;
                     if (w_last_rd) begin
                        r_state      <= S_IDLE;
                        r_fifo_lleno <= 1'b0;
                     end
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_rd_data      = r_rd_data;
   assign o_rd_valid     = r_rd_valid;
   assign o_busy         = r_busy;
   assign o_fifo_lleno   = r_fifo_lleno;
   assign o_sample_count = r_sample_count;
   assign o_rd_ignored   = r_rd_ignored;

endmodule

// File: tb/tb_stream_capture_reader.sv
// Directed bench for stream_capture_reader: one instance without and one with a skip window.
module tb_stream_capture_reader;
`ifdef CAPTURE_SPLIT32_EN
   localparam int RD_W = 32;
`else
   localparam int RD_W = 64;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            enable = 1'b1;
   logic            data_valid = 1'b0;
   logic [63:0]     data = '0;
   logic            arm0 = 1'b0, arm3 = 1'b0;
   logic            rd_req0 = 1'b0, rd_req3 = 1'b0;
   logic [15:0]     cap_len = '0;
   logic [RD_W-1:0] rd_data0, rd_data3;
   logic            rd_valid0, rd_valid3, busy0, busy3, full0, full3, ign0, ign3;
   logic [15:0]     cnt0, cnt3;

   int              n_checks = 0;
   int              n_errors = 0;
   logic [63:0]     w;
   logic            vld;

   always #5 clk = ~clk;

   stream_capture_reader #(.DATA_W(64), .DEPTH(2048), .ADDR_W(11), .SKIP_SAMPLES(0)) dut0 (
      .i_clock(clk), .i_reset(rst), .i_enable(enable), .i_data_valid(data_valid),
      .i_data(data), .i_arm(arm0), .i_capture_len(cap_len), .i_rd_req(rd_req0),
      .o_rd_data(rd_data0), .o_rd_valid(rd_valid0), .o_busy(busy0),
      .o_fifo_lleno(full0), .o_sample_count(cnt0), .o_rd_ignored(ign0));

   stream_capture_reader #(.DATA_W(64), .DEPTH(2048), .ADDR_W(11), .SKIP_SAMPLES(3)) dut3 (
      .i_clock(clk), .i_reset(rst), .i_enable(enable), .i_data_valid(data_valid),
      .i_data(data), .i_arm(arm3), .i_capture_len(cap_len), .i_rd_req(rd_req3),
      .o_rd_data(rd_data3), .o_rd_valid(rd_valid3), .o_busy(busy3),
      .o_fifo_lleno(full3), .o_sample_count(cnt3), .o_rd_ignored(ign3));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic single_read(input int sel, output logic [63:0] v, output logic ok);
      @(negedge clk);
      if (sel == 0) rd_req0 = 1'b1;
      else          rd_req3 = 1'b1;
      @(negedge clk);
      rd_req0 = 1'b0;
      rd_req3 = 1'b0;
      v  = (sel == 0) ? 64'(rd_data0) : 64'(rd_data3);
      ok = (sel == 0) ? rd_valid0 : rd_valid3;
   endtask

   task automatic do_read(input int sel, output logic [63:0] v, output logic ok);
`ifdef CAPTURE_SPLIT32_EN
      logic [63:0] lo, hi;
      logic        ok_lo, ok_hi;
      single_read(sel, lo, ok_lo);
      single_read(sel, hi, ok_hi);
      v  = {hi[31:0], lo[31:0]};
      ok = ok_lo && ok_hi;
`else
      single_read(sel, v, ok);
`endif
   endtask

   task automatic read_expect(input int sel, input string tag, input logic [63:0] exp);
      logic [63:0] v;
      logic        ok;
      do_read(sel, v, ok);
      check({tag, "_vld"}, 64'(ok), 64'd1);
      check(tag, v, exp);
   endtask

   task automatic feed(input logic [63:0] v, input int gap);
      @(negedge clk);
      data       = v;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic arm_dut(input int sel, input logic [15:0] len, input logic with_rd);
      @(negedge clk);
      cap_len = len;
      if (sel == 0) begin
         arm0    = 1'b1;
         rd_req0 = with_rd;
      end else begin
         arm3    = 1'b1;
         rd_req3 = with_rd;
      end
      @(negedge clk);
      arm0    = 1'b0;
      arm3    = 1'b0;
      rd_req0 = 1'b0;
      rd_req3 = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] first_v, last_v;
      logic        all_ok;
      logic [63:0] base;
      int          step;

      repeat (2) @(negedge clk);
      check("rst_cnt", 64'(cnt0), 64'd0);
      check("rst_busy", 64'(busy0), 64'd0);
      check("rst_full", 64'(full0), 64'd0);
      check("rst_rdv", 64'(rd_valid0), 64'd0);
      check("rst_data", 64'(rd_data0), 64'd0);
      rst = 1'b0;

      // basic capture and readout
      single_read(0, w, vld);
      check("idle_rd_vld", 64'(vld), 64'd0);
      check("idle_rd_ign", 64'(ign0), 64'd1);
      arm_dut(0, 16'd4, 1'b0);
      check("arm_clr_ign", 64'(ign0), 64'd0);
      check("arm_busy", 64'(busy0), 64'd1);
      feed(64'd10, 1);
      feed(-64'sd20, 2);
      feed(64'd30, 0);
      check("t1_cnt3", 64'(cnt0), 64'd3);
      check("t1_full3", 64'(full0), 64'd0);
      feed(-64'sd40, 1);
      check("t1_cnt4", 64'(cnt0), 64'd4);
      check("t1_full4", 64'(full0), 64'd1);
      check("t1_busy4", 64'(busy0), 64'd0);
      feed(64'd50, 0);
      check("t1_drop_full", 64'(cnt0), 64'd4);
      read_expect(0, "t1_r0", 64'd10);
      read_expect(0, "t1_r1", -64'sd20);
      check("t1_full_mid", 64'(full0), 64'd1);
      read_expect(0, "t1_r2", 64'd30);
      read_expect(0, "t1_r3", -64'sd40);
      check("t1_idle_full", 64'(full0), 64'd0);
      check("t1_idle_busy", 64'(busy0), 64'd0);
      single_read(0, w, vld);
      check("t1_r4_vld", 64'(vld), 64'd0);
      check("t1_r4_ign", 64'(ign0), 64'd1);

      // enable low during capture, reads with enable low
      arm_dut(0, 16'd4, 1'b1);
      check("t2_arm_rd_ign", 64'(ign0), 64'd1);
      check("t2_busy", 64'(busy0), 64'd1);
      feed(64'd101, 0);
      @(negedge clk);
      enable     = 1'b0;
      data_valid = 1'b1;
      data       = 64'd999;
      repeat (5) @(negedge clk);
      data_valid = 1'b0;
      enable     = 1'b1;
      check("t2_en_low_cnt", 64'(cnt0), 64'd1);
      feed(64'd102, 0);
      feed(64'd103, 0);
      feed(64'd104, 0);
      check("t2_cnt", 64'(cnt0), 64'd4);
      check("t2_full", 64'(full0), 64'd1);
      enable = 1'b0;
      read_expect(0, "t2_r0", 64'd101);
      read_expect(0, "t2_r1", 64'd102);
      read_expect(0, "t2_r2", 64'd103);
      read_expect(0, "t2_r3", 64'd104);
      check("t2_idle", 64'(full0), 64'd0);
      enable = 1'b1;

      // skip window of 3 on the second instance
      arm_dut(3, 16'd2, 1'b0);
      check("t3_busy", 64'(busy3), 64'd1);
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         data       = 64'(i);
         data_valid = 1'b1;
      end
      @(negedge clk);
      data_valid = 1'b0;
      check("t3_cnt", 64'(cnt3), 64'd2);
      check("t3_full", 64'(full3), 64'd1);
      read_expect(3, "t3_r0", 64'd4);
      read_expect(3, "t3_r1", 64'd5);
      check("t3_idle", 64'(full3), 64'd0);

      // async reset mid-capture, then re-arm
      arm_dut(0, 16'd8, 1'b0);
      feed(64'd201, 0);
      feed(64'd202, 0);
      check("t4_cnt2", 64'(cnt0), 64'd2);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("t4_rst_busy", 64'(busy0), 64'd0);
      check("t4_rst_cnt", 64'(cnt0), 64'd0);
      check("t4_rst_full", 64'(full0), 64'd0);
      check("t4_rst_rdv", 64'(rd_valid0), 64'd0);
      check("t4_rst_ign", 64'(ign0), 64'd0);
      check("t4_rst_data0", 64'(rd_data0), 64'd0);
      check("t4_rst_data3", 64'(rd_data3), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      arm_dut(0, 16'd3, 1'b0);
      feed(64'd301, 0);
      arm_dut(0, 16'd1, 1'b0);
      check("t4_busy_arm_cnt", 64'(cnt0), 64'd1);
      check("t4_busy_arm_busy", 64'(busy0), 64'd1);
      check("t4_busy_arm_full", 64'(full0), 64'd0);
      feed(64'd302, 0);
      feed(64'd303, 0);
      check("t4_cnt3", 64'(cnt0), 64'd3);
      check("t4_full", 64'(full0), 64'd1);
      read_expect(0, "t4_r0", 64'd301);
      read_expect(0, "t4_r1", 64'd302);
      read_expect(0, "t4_r2", 64'd303);
      check("t4_idle", 64'(full0), 64'd0);

      // length clamp: 0 and 5000 both capture exactly DEPTH samples
      for (int k = 0; k < 2; k++) begin
         base = (k == 0) ? 64'd1000 : 64'd50000;
         step = (k == 0) ? 1 : 3;
         arm_dut(0, (k == 0) ? 16'd0 : 16'd5000, 1'b0);
         for (int i = 0; i < 2049; i++) begin
            @(negedge clk);
            data       = base + 64'(i * step);
            data_valid = 1'b1;
         end
         @(negedge clk);
         data_valid = 1'b0;
         check("t5_cnt", 64'(cnt0), 64'd2048);
         check("t5_full", 64'(full0), 64'd1);
         all_ok  = 1'b1;
         first_v = '0;
         last_v  = '0;
         for (int i = 0; i < 2048; i++) begin
            do_read(0, w, vld);
            if (i == 0) first_v = w;
            if (i == 2047) last_v = w;
            if (!vld || w !== base + 64'(i * step)) all_ok = 1'b0;
         end
         check("t5_first", first_v, base);
         check("t5_last", last_v, base + 64'(2047 * step));
         check("t5_all", 64'(all_ok), 64'd1);
         check("t5_idle", 64'(full0), 64'd0);
      end

`ifdef CAPTURE_SPLIT32_EN
      arm_dut(0, 16'd1, 1'b0);
      feed(64'h1122334455667788, 0);
      check("t6_full", 64'(full0), 64'd1);
      single_read(0, w, vld);
      check("t6_lo_vld", 64'(vld), 64'd1);
      check("t6_lo", w, 64'h55667788);
      check("t6_full_mid", 64'(full0), 64'd1);
      single_read(0, w, vld);
      check("t6_hi_vld", 64'(vld), 64'd1);
      check("t6_hi", w, 64'h11223344);
      check("t6_idle", 64'(full0), 64'd0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
